// File: rtl/router_pkg.sv
// Shared defaults and helpers for the NxN output-queued router.
package router_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // Destination field width; two ports still need one select bit.
    function automatic int dest_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_if.sv
// Router port bundle: per-port buses flattened, port p at [p*W +: W].
interface router_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8
);
    logic [NUM_PORTS*ADDR_W-1:0] addr_in;
    logic [NUM_PORTS*DATA_W-1:0] data_in;
    logic [NUM_PORTS-1:0]        valid_in;
    logic [NUM_PORTS-1:0]        rcv_rdy;
    logic [NUM_PORTS*ADDR_W-1:0] addr_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        valid_out;
    logic [NUM_PORTS-1:0]        data_rd;
    logic                        drop_err;

    modport master (
        output addr_in, data_in, valid_in, data_rd,
        input  rcv_rdy, addr_out, data_out, valid_out, drop_err
    );

    modport slave (
        input  addr_in, data_in, valid_in, data_rd,
        output rcv_rdy, addr_out, data_out, valid_out, drop_err
    );
endinterface

// File: rtl/router_fifo.sv
// First-word-fall-through output queue; head reads as zero when empty.
module router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/router_nxn.sv
// NxN router: per-output round-robin arbitration feeding per-output FWFT queues.
module router_nxn
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic     clk,
    input logic     reset,
    router_if.slave bus
);
    localparam int DW = dest_w(NUM_PORTS);
    localparam int EW = ADDR_W + DATA_W;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_i, addr_o;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_i, data_o;
    logic [NUM_PORTS-1:0][DW-1:0]     dest, rr, gidx;
    logic [NUM_PORTS-1:0][EW-1:0]     wdata, rdata;
    logic [NUM_PORTS-1:0]             bad, gvld, full, empty, push, rdy;
    logic                             drop_q;

    assign addr_i = bus.addr_in;
    assign data_i = bus.data_in;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
        assign dest[i] = addr_i[i][DW-1:0];
        assign bad[i]  = (int'(dest[i]) >= NUM_PORTS);
    end

    // Round-robin: the requester with the smallest upward distance from rr[o] wins.
    always_comb begin
        int best;
        int d;
        gvld = '0;
        gidx = '0;
        best = 0;
        d    = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            best = NUM_PORTS;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.valid_in[i] && !bad[i] && int'(dest[i]) == o) begin
                    d = i - int'(rr[o]);
                    if (d < 0) d = d + NUM_PORTS;
                    if (d < best) begin
                        best    = d;
                        gidx[o] = DW'(i);
                    end
                end
            end
            gvld[o]  = (best < NUM_PORTS);
            push[o]  = gvld[o] && !full[o];
            wdata[o] = {addr_i[gidx[o]], data_i[gidx[o]]};
        end
    end

    // Bad destinations are accepted unconditionally and dropped.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rdy[i] = reset && bus.valid_in[i] &&
                     (bad[i] || (gvld[dest[i]] && gidx[dest[i]] == DW'(i) && !full[dest[i]]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr     <= '0;
            drop_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (push[o]) rr[o] <= (gidx[o] == DW'(NUM_PORTS-1)) ? '0 : gidx[o] + 1'b1;
            end
            drop_q <= |(bus.valid_in & bad);
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_q
        router_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[o]),
            .wdata (wdata[o]),
            .pop   (bus.data_rd[o]),
            .rdata (rdata[o]),
            .full  (full[o]),
            .empty (empty[o])
        );
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            addr_o[o] = rdata[o][EW-1:DATA_W];
            data_o[o] = rdata[o][DATA_W-1:0];
        end
    end

    assign bus.rcv_rdy   = rdy;
    assign bus.valid_out = ~empty;
    assign bus.addr_out  = addr_o;
    assign bus.data_out  = data_o;
    assign bus.drop_err  = drop_q;
endmodule

// File: doc/router_nxn.md
ROUTER_NXN -- requirements
Module: router_nxn

Interface
REQ-001 Parameters SHALL be: NUM_PORTS, default 4, number of input and output ports (2..8); DATA_W, default 8, payload width; ADDR_W, default 8, address width; FIFO_DEPTH, default 8, words per output queue (power of 2, >=2).
REQ-002 Ports (per-port buses flattened, port p at bits [p*W +: W]) SHALL be:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- addr_in  in  NUM_PORTS*ADDR_W  destination address per input
- data_in  in  NUM_PORTS*DATA_W  payload per input
- valid_in  in  NUM_PORTS  input word offered
- rcv_rdy  out  NUM_PORTS  input word accepted this edge
- addr_out  out  NUM_PORTS*ADDR_W  address of head word per output
- data_out  out  NUM_PORTS*DATA_W  payload of head word per output
- valid_out  out  NUM_PORTS  output queue non-empty
- data_rd  in  NUM_PORTS  consumer pops head word
- drop_err  out  1  one-cycle pulse: word discarded for bad address

Function
REQ-003 Destination of input i SHALL be addr_in[i] bits [DW-1:0], DW = clog2(NUM_PORTS); upper address bits are carried unmodified.
REQ-004 An input transfer SHALL occur on a rising edge where valid_in[i] and rcv_rdy[i] are both 1.
REQ-005 rcv_rdy[i] SHALL be combinational: 1 only if valid_in[i]=1, input i holds the grant for its destination, and that output FIFO is not full at the start of the cycle (no same-cycle pop credit).
REQ-006 Each output o SHALL have one round-robin arbiter; the grant goes to the first requesting input at or after pointer rr[o], searching upward with wrap from NUM_PORTS-1 to 0.
REQ-007 rr[o] SHALL advance to (grantee+1) mod NUM_PORTS only on an accepted transfer; otherwise it SHALL hold.
REQ-008 At most one word per output SHALL be written per cycle; distinct outputs SHALL accept in parallel, up to NUM_PORTS words per cycle.
REQ-009 A destination index >= NUM_PORTS SHALL be accepted (rcv_rdy=1, no arbitration), discarded, and SHALL pulse drop_err for the following cycle.
REQ-010 Output queues SHALL be first-word fall-through: a word accepted at edge k SHALL appear on valid_out/addr_out/data_out after edge k.
REQ-011 A pop SHALL occur on an edge where valid_out[o] and data_rd[o] are both 1; data_rd with an empty queue SHALL be ignored.
REQ-012 Simultaneous push and pop on a non-full queue SHALL keep occupancy unchanged and preserve order.
REQ-013 Per-output ordering SHALL be preserved; words from the same input to the same output SHALL never reorder.
REQ-014 When a queue is empty, addr_out and data_out for that port SHALL be driven to 0.
REQ-015 FIFO read/write pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, with full and empty derived from the extra wrap bit.

Reset
REQ-016 reset=0 SHALL asynchronously empty all queues, set every rr[o]=0, and drive valid_out=0, addr_out=0, data_out=0, drop_err=0.
REQ-017 While reset=0, rcv_rdy SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard all queued words; no partial word SHALL appear after release.
REQ-019 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-020 Package router_pkg SHALL hold the default parameter constants and a function computing DW from NUM_PORTS.
REQ-021 Sub-module router_fifo (parameters DATA_W+ADDR_W, FIFO_DEPTH) SHALL implement one output queue and SHALL be instantiated NUM_PORTS times; arbitration SHALL stay in router_nxn.

Verification
REQ-022 Single path: input 0 sends addr 0x02, data 0xA5 -> valid_out[2]=1 next cycle with addr_out=0x02, data_out=0xA5; data_rd[2] pulse -> valid_out[2]=0.
REQ-023 Contention: inputs 0,1,3 all target output 1 continuously from reset with data_rd[1]=1 -> acceptance order 0,1,3,0,1,3 and exactly one rcv_rdy high per cycle.
REQ-024 Full/backpressure: FIFO_DEPTH=4, 5 words to output 3 with data_rd[3]=0 -> 4 accepted, rcv_rdy low on 5th; one pop -> 5th accepted next edge.
REQ-025 Parallel: inputs 0..3 target outputs 3,2,1,0 in the same cycle -> all four rcv_rdy=1; all valid_out=1 next cycle.
REQ-026 Bad address with NUM_PORTS=3: addr_in=0x03 -> rcv_rdy=1, drop_err pulses one cycle, no valid_out change.
REQ-027 Reset mid-stream: 3 words queued at output 0, then reset=0 asynchronously -> valid_out=0 immediately; after release the queue stays empty.
